// File: rtl/vec_mul_pipe.sv
// Handshaked SIMD multiplier: packed operands split into 8/16/32/64-bit lanes, MUL/MULH/MULHU/MULHSU.
// Datapath: sign-magnitude operands -> 8x8 partial-product array -> per-lane sum -> sign fix-up.
module vec_mul_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [1:0]      opcode,
    input  logic [1:0]      precision,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mul_out,
    output logic            illegal
);
    localparam int unsigned NB = XLEN / 8;

    typedef enum logic [1:0] {
        OpMul    = 2'b00,
        OpMulh   = 2'b01,
        OpMulhu  = 2'b10,
        OpMulhsu = 2'b11
    } op_e;

    logic stall, adv, in_fire;
    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall && !flush;
    assign in_fire  = in_valid && in_ready;

    // ---------------- stage 1: sign-magnitude conversion ----------------
    logic sgn_a, sgn_b;
    assign sgn_a = (opcode == OpMulh) || (opcode == OpMulhsu);
    assign sgn_b = (opcode == OpMulh);

    logic [3:0][XLEN-1:0] cand_mag_a, cand_mag_b;
    logic [3:0][NB-1:0]   cand_neg;

    for (genvar p = 0; p < 4; p++) begin : g_prec_in
        localparam int unsigned LW = 8 << p;
        localparam int unsigned LB = LW / 8;
        if (LW <= XLEN) begin : g_en
            for (genvar l = 0; l < XLEN / LW; l++) begin : g_lane
                logic [LW-1:0] la, lb;
                logic          na, nb;
                assign la = operand_a[l*LW +: LW];
                assign lb = operand_b[l*LW +: LW];
                assign na = sgn_a && la[LW-1];
                assign nb = sgn_b && lb[LW-1];
                assign cand_mag_a[p][l*LW +: LW] = na ? -la : la;
                assign cand_mag_b[p][l*LW +: LW] = nb ? -lb : lb;
                // Result sign replicated over every byte of the lane.
                assign cand_neg[p][l*LB +: LB] = {LB{na ^ nb}};
            end
        end else begin : g_dis
            assign cand_mag_a[p] = '0;
            assign cand_mag_b[p] = '0;
            assign cand_neg[p]   = '0;
        end
    end

    logic            s1_valid;
    logic [XLEN-1:0] s1_mag_a, s1_mag_b;
    logic [NB-1:0]   s1_neg;
    logic [1:0]      s1_op, s1_prec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mag_a <= '0;
            s1_mag_b <= '0;
            s1_neg   <= '0;
            s1_op    <= '0;
            s1_prec  <= '0;
        end else begin
            if (flush)    s1_valid <= 1'b0;
            else if (adv) s1_valid <= in_fire;
            if (in_fire) begin
                s1_mag_a <= cand_mag_a[precision];
                s1_mag_b <= cand_mag_b[precision];
                s1_neg   <= cand_neg[precision];
                s1_op    <= opcode;
                s1_prec  <= precision;
            end
        end
    end

    // ---------------- 8x8 partial-product array ----------------
    logic [NB*NB-1:0][15:0] pp_c;
    always_comb begin
        pp_c = '0;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
                pp_c[i*NB+j] = 16'(s1_mag_a[i*8 +: 8]) * 16'(s1_mag_b[j*8 +: 8]);
            end
        end
    end

    logic                   pp_valid;
    logic [NB*NB-1:0][15:0] pp_v;
    logic [NB-1:0]          pp_neg;
    logic [1:0]             pp_op, pp_prec;

    if (PIPE_STAGES >= 3) begin : g_pp_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pp_valid <= 1'b0;
                pp_v     <= '0;
                pp_neg   <= '0;
                pp_op    <= '0;
                pp_prec  <= '0;
            end else begin
                if (flush)    pp_valid <= 1'b0;
                else if (adv) pp_valid <= s1_valid;
                if (adv && s1_valid) begin
                    pp_v    <= pp_c;
                    pp_neg  <= s1_neg;
                    pp_op   <= s1_op;
                    pp_prec <= s1_prec;
                end
            end
        end
    end else begin : g_pp_comb
        assign pp_valid = s1_valid;
        assign pp_v     = pp_c;
        assign pp_neg   = s1_neg;
        assign pp_op    = s1_op;
        assign pp_prec  = s1_prec;
    end

    // ---------------- per-lane magnitude products (lane l at [2*l*W +: 2W]) ----------------
    logic [3:0][2*XLEN-1:0] cand_prod;

    for (genvar p = 0; p < 4; p++) begin : g_prec_sum
        localparam int unsigned LW = 8 << p;
        localparam int unsigned LB = LW / 8;
        if (LW <= XLEN) begin : g_en
            for (genvar l = 0; l < XLEN / LW; l++) begin : g_lane
                logic [2*LW-1:0] acc;
                always_comb begin
                    acc = '0;
                    for (int i = 0; i < LB; i++) begin
                        for (int j = 0; j < LB; j++) begin
                            acc = acc + ((2*LW)'(pp_v[(l*LB+i)*NB + l*LB + j]) << (8*(i+j)));
                        end
                    end
                end
                assign cand_prod[p][2*l*LW +: 2*LW] = acc;
            end
        end else begin : g_dis
            assign cand_prod[p] = '0;
        end
    end

    logic              prod_valid;
    logic [2*XLEN-1:0] prod_v;
    logic [NB-1:0]     prod_neg;
    logic [1:0]        prod_op, prod_prec;

    if (PIPE_STAGES >= 4) begin : g_prod_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                prod_valid <= 1'b0;
                prod_v     <= '0;
                prod_neg   <= '0;
                prod_op    <= '0;
                prod_prec  <= '0;
            end else begin
                if (flush)    prod_valid <= 1'b0;
                else if (adv) prod_valid <= pp_valid;
                if (adv && pp_valid) begin
                    prod_v    <= cand_prod[pp_prec];
                    prod_neg  <= pp_neg;
                    prod_op   <= pp_op;
                    prod_prec <= pp_prec;
                end
            end
        end
    end else begin : g_prod_comb
        assign prod_valid = pp_valid;
        assign prod_v     = cand_prod[pp_prec];
        assign prod_neg   = pp_neg;
        assign prod_op    = pp_op;
        assign prod_prec  = pp_prec;
    end

    // ---------------- two's-complement correction and lane select ----------------
    logic [3:0][XLEN-1:0] cand_res;

    for (genvar p = 0; p < 4; p++) begin : g_prec_out
        localparam int unsigned LW = 8 << p;
        localparam int unsigned LB = LW / 8;
        if (LW <= XLEN) begin : g_en
            for (genvar l = 0; l < XLEN / LW; l++) begin : g_lane
                logic [2*LW-1:0] x, sx;
                assign x  = prod_v[2*l*LW +: 2*LW];
                assign sx = prod_neg[l*LB] ? -x : x;
                assign cand_res[p][l*LW +: LW] = (prod_op == OpMul) ? sx[LW-1:0] : sx[2*LW-1:LW];
            end
        end else begin : g_dis
            assign cand_res[p] = '0;
        end
    end

    logic            illegal_c;
    logic [XLEN-1:0] res_c;
    assign illegal_c = (XLEN == 32) && (prod_prec == 2'b11);
    assign res_c     = illegal_c ? '0 : cand_res[prod_prec];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            mul_out   <= '0;
            illegal   <= 1'b0;
        end else begin
            if (flush)    out_valid <= 1'b0;
            else if (adv) out_valid <= prod_valid;
            // Data only loads with a live result, so mul_out holds while out_valid is low.
            if (adv && prod_valid) begin
                mul_out <= res_c;
                illegal <= illegal_c;
            end
        end
    end

endmodule

// File: doc/vec_mul_pipe.md
Name: vec_mul_pipe

Overview:
- Parametrised, handshaked successor to the 32-bit precision-controlled vector multiplier top.
- Accepts one packed vector operand pair per transfer and splits it into SIMD lanes of 8/16/32/64 bits.
- Computes per-lane MUL/MULH/MULHU/MULHSU results through a configurable-depth pipeline.
- Adds valid/ready flow control, stall, flush and an illegal-config flag; sits between the vector issue stage and writeback.

Parameters:
XLEN, 32, datapath width in bits; legal values 32 or 64.
PIPE_STAGES, 3, accept-to-output latency in cycles; legal range 2..4.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept this cycle
operand_a  input  XLEN  packed vector operand A
operand_b  input  XLEN  packed vector operand B
opcode  input  2  00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
precision  input  2  00 8b, 01 16b, 10 32b, 11 64b lanes
flush  input  1  synchronous pipeline kill
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
mul_out  output  XLEN  packed per-lane results
illegal  output  1  qualifies mul_out; set if precision illegal for XLEN

Behaviour:
- Reset (rst low, asynchronous): every stage valid bit cleared. out_valid=0, mul_out=0, illegal=0, in_ready=1 one cycle after deassertion.
- Transfer rules: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
- in_valid and operands must be held stable until accepted.
- Global stall = out_valid && !out_ready. in_ready = !stall. During stall, every stage register and its valid bit holds.
- Latency: with no stall, a pair accepted in cycle N produces out_valid in cycle N+PIPE_STAGES. Throughput is one transfer per cycle.
- Ordering: results leave in acceptance order; none lost or duplicated.
- Sideband: opcode, precision and per-lane sign bits travel with their operands through every stage; there is no separate sideband register path.
- Lane arithmetic, lane width W = 8 << precision:
  - MUL: low W bits of the 2W-bit product.
  - MULH: high W bits, both operands signed.
  - MULHU: high W bits, both operands unsigned.
  - MULHSU: high W bits, A signed, B unsigned.
- Lane packing: lane i occupies bits [i*W +: W] of inputs and output.
- Datapath decomposition:
  - Stage 1 registers operands and sign-magnitude conversion.
  - Middle stages hold partial products of the 8x8 sub-block array.
  - Final stage does two's-complement correction and lane select.
- Illegal precision: precision=11 with XLEN=32. The transfer is still accepted; its output carries mul_out=0 and illegal=1 with normal latency. For all legal transfers illegal=0.
- Flush: in a cycle with flush=1, all valid bits clear on the next edge, including the output register and regardless of stall.
  - No input is accepted in that cycle; in_ready=0 while flush=1.
  - mul_out data value after flush is don't-care; out_valid=0.
- Reset mid-operation: all in-flight results are discarded; no out_valid after rst deasserts until a new transfer has completed PIPE_STAGES.
- Simultaneous output and input transfer in the same cycle when the pipeline is full: legal; pipeline advances one slot.
- out_valid low: mul_out holds its last value and has no meaning.

Test Plan:
1. XLEN=32, precision=10, MUL, a=0x00000007, b=0x00000006, out_ready=1 -> out_valid exactly 3 cycles after accept, mul_out=0x0000002A, illegal=0.
2. precision=00, MULH, a=0x8080FF7F, b=0x807FFF7F -> mul_out=0x40C0003F.
3. precision=01, MULHU, a=0xFFFF0002, b=0xFFFF8000 -> mul_out=0xFFFE0001. Same operands with MULH -> 0x0000FFFF.
4. precision=10, MULHSU, a=0xFFFFFFFF, b=0x00000002 -> mul_out=0xFFFFFFFF. Then precision=11 with XLEN=32 -> mul_out=0, illegal=1.
5. Five back-to-back transfers (MUL 32b, a=k, b=k for k=1..5), out_ready low for 4 cycles once the first result appears:
   - in_ready=0 throughout the stall.
   - Outputs are 1, 4, 9, 16, 25, in order, with no duplicates.
   - After out_ready rises, one result per cycle.
6. Three transfers in flight:
   - flush=1 for one cycle -> out_valid stays 0 for the next PIPE_STAGES cycles.
   - Repeat with rst pulsed low mid-stream -> outputs 0, no stale result emitted.
   - XLEN=64 build: precision=11, MUL, a=b=0x0000000100000000 -> mul_out=0.
